fir_coeff_sequencer: RTL

//  Control front-end for the symmetric FIR datapath; holds NUM_SETS coefficient banks.
//  On request, clears the filter, streams one bank through its load/coeff_value port,

---
 rtl/fir_coeff_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: coefficient-bank store and load/fill sequencer in front of a symmetric FIR
// Ports: clk_i clock; clr_n_i sync active-low reset;
//   wr_en_i/wr_set_i/wr_idx_i/wr_data_i host bank write, wr_err_o write-rejected pulse;
//   cfg_req_i/cfg_sel_i bank switch request, cfg_done_o new bank live pulse, cfg_err_o bad select pulse;
//   busy_o sequence in progress, active_set_o bank currently applied;
//   fir_clr_o/fir_load_o/fir_coeff_o FIR control (registered);
//   in_ready_o samples may enter, out_valid_o filter output meaningful;
//   sample_cnt_o RUN cycle counter, present only when FIR_SEQ_SAMPLE_CNT_EN is defined.
module fir_coeff_sequencer #(
  parameter int COEFF_NUM = 6,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_SETS = 4,
  parameter int FILL_CYCLES = 16,
  localparam int SW = $clog2(NUM_SETS),
  localparam int IW = $clog2(COEFF_NUM),
  localparam int FW = $clog2(FILL_CYCLES + 1)
) (
  input  logic                   clk_i,
  input  logic                   clr_n_i,
  input  logic                   wr_en_i,
  input  logic [SW-1:0]          wr_set_i,
  input  logic [IW-1:0]          wr_idx_i,
  input  logic [COEFF_WIDTH-1:0] wr_data_i,
  output logic                   wr_err_o,
  input  logic                   cfg_req_i,
  input  logic [SW-1:0]          cfg_sel_i,
  output logic                   cfg_done_o,
  output logic                   cfg_err_o,
  output logic                   busy_o,
  output logic [SW-1:0]          active_set_o,
  output logic                   fir_clr_o,
  output logic                   fir_load_o,
  output logic [COEFF_WIDTH-1:0] fir_coeff_o,
  output logic                   in_ready_o,
  output logic                   out_valid_o
`ifdef FIR_SEQ_SAMPLE_CNT_EN
  ,
  output logic [15:0]            sample_cnt_o
);
`else
);
`endif
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FINAL, FILL, RUN} state_e;
  state_e state_q, state_d;
  logic [COEFF_WIDTH-1:0] bank_q [NUM_SETS][COEFF_NUM];
  logic [SW-1:0] sel_q, active_set_q;
  logic [IW-1:0] tap_q;
  logic [FW-1:0] fill_q;
  logic fir_clr_q, fir_clr_d, fir_load_q, fir_load_d;
  logic [COEFF_WIDTH-1:0] fir_coeff_q, fir_coeff_d;
  logic cfg_done_q, cfg_done_d, cfg_err_q, wr_err_q;
  logic can_req, sel_ok, accept, wr_ok, last_tap, fill_end;
  assign can_req = state_q == IDLE || state_q == RUN;
  assign sel_ok = int'(cfg_sel_i) < NUM_SETS;
  assign accept = cfg_req_i && can_req && sel_ok;
  // the bank being streamed is locked against writes while LOAD reads it
  assign wr_ok = wr_en_i && int'(wr_idx_i) < COEFF_NUM && int'(wr_set_i) < NUM_SETS &&
                 !(state_q == LOAD && wr_set_i == sel_q);
  assign last_tap = tap_q == IW'(COEFF_NUM - 1);
  assign fill_end = fill_q == '0;
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: state_d = accept ? CLEAR : state_q;
      CLEAR:     state_d = LOAD;
      LOAD:      state_d = last_tap ? FINAL : LOAD;
      FINAL:     state_d = FILL;
      FILL:      state_d = fill_end ? RUN : FILL;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    fir_clr_d = state_q == CLEAR;
    fir_load_d = state_q == LOAD || state_q == FINAL;
    fir_coeff_d = state_q == LOAD ? bank_q[sel_q][tap_q] : '0;
    cfg_done_d = state_q == FILL && fill_end;
    busy_o = state_q == CLEAR || state_q == LOAD || state_q == FINAL || state_q == FILL;
    in_ready_o = state_q == FILL || state_q == RUN;
    out_valid_o = state_q == RUN;
  end
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int k = 0; k < COEFF_NUM; k++)
          bank_q[s][k] <= '0;
      sel_q <= '0;
      active_set_q <= '0;
      tap_q <= '0;
      fill_q <= '0;
      fir_clr_q <= 1'b0;
      fir_load_q <= 1'b0;
      fir_coeff_q <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      if (wr_ok) bank_q[wr_set_i][wr_idx_i] <= wr_data_i;
      if (accept) sel_q <= cfg_sel_i;
      if (cfg_done_d) active_set_q <= sel_q;
      tap_q <= state_q == CLEAR ? '0 : state_q == LOAD && !last_tap ? tap_q + 1'b1 : tap_q;
      fill_q <= state_q == FINAL ? FW'(FILL_CYCLES - 1) :
                state_q == FILL && !fill_end ? fill_q - 1'b1 : fill_q;
      fir_clr_q <= fir_clr_d;
      fir_load_q <= fir_load_d;
      fir_coeff_q <= fir_coeff_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q <= cfg_req_i && can_req && !sel_ok;
      wr_err_q <= wr_en_i && !wr_ok;
    end
  end
  assign wr_err_o = wr_err_q;
  assign cfg_done_o = cfg_done_q;
  assign cfg_err_o = cfg_err_q;
  assign active_set_o = active_set_q;
  assign fir_clr_o = fir_clr_q;
  assign fir_load_o = fir_load_q;
  assign fir_coeff_o = fir_coeff_q;
`ifdef FIR_SEQ_SAMPLE_CNT_EN
  logic [15:0] sample_cnt_q;
  always_ff @(posedge clk_i) begin
    if (!clr_n_i || state_q == CLEAR) sample_cnt_q <= '0;
    else if (state_q == RUN && sample_cnt_q != 16'hFFFF) sample_cnt_q <= sample_cnt_q + 1'b1;
  end
  assign sample_cnt_o = sample_cnt_q;
`endif
endmodule
